// File: rtl/scale_sync_fifo.sv
// Synchronous single-clock FIFO with registered status flags and optional first-word-fall-through.
// Optional sticky overflow/underflow outputs exist only when SCALE_SYNC_FIFO_ERR_FLAG_EN is defined.
module scale_sync_fifo #(
  parameter int DATA_WIDTH       = 16,
  parameter int DEPTH_WIDTH      = 11,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int FWFT             = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [DEPTH_WIDTH:0]  water_level
`ifdef SCALE_SYNC_FIFO_ERR_FLAG_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [DEPTH_WIDTH:0] FULL_LVL = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] AF_LVL   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_LVL   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
  localparam logic [DEPTH_WIDTH:0] ZERO_LVL = {(DEPTH_WIDTH+1){1'b0}};
  localparam logic [DEPTH_WIDTH:0] ONE_LVL  = (DEPTH_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0]  mem [0:(1<<DEPTH_WIDTH)-1];
  logic [DATA_WIDTH-1:0]  rd_data_q;
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   level_q, level_d;
  logic                   full_q, full_d, afull_q, afull_d;
  logic                   empty_q, empty_d, aempty_q, aempty_d;
  logic                   wr_acc_s, rd_acc_s, load_mem_s, load_byp_s;

  // Acceptance, output-register load selection and next-state of pointers/level/flags.
  always_comb begin
    wr_acc_s   = wr_en & ~full_q & rst_n;
    rd_acc_s   = rd_en & ~empty_q & rst_n;
    load_mem_s = 1'b0;
    load_byp_s = 1'b0;
    if (FWFT != 0) begin
      // The presented word lives in rd_data_q; refill it from RAM, or straight from
      // wr_data when the RAM holds nothing behind it.
      if (empty_q | rd_acc_s) begin
        if (level_q > ONE_LVL) begin
          load_mem_s = rst_n;
        end else begin
          load_byp_s = wr_acc_s;
        end
      end else begin
        load_mem_s = 1'b0;
      end
    end else begin
      load_mem_s = rd_acc_s;
    end
    wr_ptr_d = wr_acc_s ? wr_ptr_q + {{(DEPTH_WIDTH-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = (load_mem_s | load_byp_s) ? rd_ptr_q + {{(DEPTH_WIDTH-1){1'b0}}, 1'b1} : rd_ptr_q;
    level_d  = level_q + (DEPTH_WIDTH+1)'(wr_acc_s) - (DEPTH_WIDTH+1)'(rd_acc_s);
    full_d   = (level_d == FULL_LVL);
    afull_d  = (level_d >= AF_LVL);
    empty_d  = (level_d == ZERO_LVL);
    aempty_d = (level_d <= AE_LVL);
  end

  // Pointer, level and status flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {DEPTH_WIDTH{1'b0}};
      rd_ptr_q <= {DEPTH_WIDTH{1'b0}};
      level_q  <= ZERO_LVL;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
    end
  end

  // Storage array write port; left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Registered read port, with write bypass for the empty-FIFO fall-through case.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= {DATA_WIDTH{1'b0}};
    end else if (load_mem_s) begin
      rd_data_q <= mem[rd_ptr_q];
    end else if (load_byp_s) begin
      rd_data_q <= wr_data;
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  assign wr_full      = full_q;
  assign almost_full  = afull_q;
  assign rd_empty     = empty_q;
  assign almost_empty = aempty_q;
  assign water_level  = level_q;
  assign rd_data      = rd_data_q;

`ifdef SCALE_SYNC_FIFO_ERR_FLAG_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  // Sticky error flags: dropped write / ignored read.
  always_comb begin
    overflow_d  = overflow_q | (wr_en & full_q);
    underflow_d = underflow_q | (rd_en & empty_q);
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_scale_sync_fifo.sv
// Self-checking bench: a standard-read and a FWFT instance share stimulus and are compared
// against a queue-based reference model each cycle.
module tb_scale_sync_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [15:0] wr_data;
  logic        full0, af0, empty0, ae0, full1, af1, empty1, ae1;
  logic [15:0] rdata0, rdata1;
  logic [4:0]  lvl0, lvl1;
`ifdef SCALE_SYNC_FIFO_ERR_FLAG_EN
  logic        ov0, un0, ov1, un1;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] q[$];
  logic [15:0] exp_rd0;
  logic        exp_ov, exp_un;

  always #5 clk = ~clk;

  scale_sync_fifo #(.DATA_WIDTH(16), .DEPTH_WIDTH(4), .ALMOST_FULL_NUM(14),
                    .ALMOST_EMPTY_NUM(2), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_full(full0),
    .almost_full(af0), .rd_en(rd_en), .rd_data(rdata0), .rd_empty(empty0),
    .almost_empty(ae0), .water_level(lvl0)
`ifdef SCALE_SYNC_FIFO_ERR_FLAG_EN
    , .overflow(ov0), .underflow(un0)
`endif
  );

  scale_sync_fifo #(.DATA_WIDTH(16), .DEPTH_WIDTH(4), .ALMOST_FULL_NUM(14),
                    .ALMOST_EMPTY_NUM(2), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_full(full1),
    .almost_full(af1), .rd_en(rd_en), .rd_data(rdata1), .rd_empty(empty1),
    .almost_empty(ae1), .water_level(lvl1)
`ifdef SCALE_SYNC_FIFO_ERR_FLAG_EN
    , .overflow(ov1), .underflow(un1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("level0", 32'(lvl0), 32'(n));
    chk("level1", 32'(lvl1), 32'(n));
    chk("full0", 32'(full0), 32'(n == 16));
    chk("full1", 32'(full1), 32'(n == 16));
    chk("afull0", 32'(af0), 32'(n >= 14));
    chk("afull1", 32'(af1), 32'(n >= 14));
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("empty1", 32'(empty1), 32'(n == 0));
    chk("aempty0", 32'(ae0), 32'(n <= 2));
    chk("aempty1", 32'(ae1), 32'(n <= 2));
    chk("rdata0", 32'(rdata0), 32'(exp_rd0));
    if (n > 0) begin
      chk("rdata1_head", 32'(rdata1), 32'(q[0]));
    end
`ifdef SCALE_SYNC_FIFO_ERR_FLAG_EN
    chk("overflow0", 32'(ov0), 32'(exp_ov));
    chk("underflow0", 32'(un0), 32'(exp_un));
    chk("overflow1", 32'(ov1), 32'(exp_ov));
    chk("underflow1", 32'(un1), 32'(exp_un));
`endif
  endtask

  // One clock: drive inputs, update the model at the edge, check just after it.
  task automatic cycle(input logic w, input logic [15:0] d, input logic r);
    int   n;
    logic wa, ra;
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      exp_rd0 = 16'h0000;
      exp_ov  = 1'b0;
      exp_un  = 1'b0;
    end else begin
      n  = q.size();
      wa = w && (n < 16);
      ra = r && (n > 0);
      if (w && !wa) exp_ov = 1'b1;
      if (r && !ra) exp_un = 1'b1;
      if (ra) exp_rd0 = q.pop_front();
      if (wa) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 16'h0000;
    exp_rd0 = 16'h0000; exp_ov = 1'b0; exp_un = 1'b0;
    cycle(1'b1, 16'hAAAA, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0);
    chk("reset_rdata1", 32'(rdata1), 32'h0);
    rst_n = 1'b1;

    // Fill 0x0000..0x000F, then a dropped write while full.
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(i), 1'b0);
    chk("fill_level16", 32'(lvl0), 32'd16);
    cycle(1'b1, 16'hDEAD, 1'b0);
    chk("drop_level16", 32'(lvl0), 32'd16);

    // Drain all 16 plus one read while empty.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 16'h0000, 1'b1);
      chk("drain_data", 32'(rdata0), 32'(i));
    end
    cycle(1'b0, 16'h0000, 1'b1);
    chk("underrun_hold", 32'(rdata0), 32'h000F);

    // Level 8 then 40 cycles of simultaneous read and write across the pointer wrap.
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 16'($urandom), 1'b1);
    chk("steady_level8", 32'(lvl1), 32'd8);

    // Random traffic, write-biased then read-biased.
    for (int i = 0; i < 150; i++)
      cycle(1'(($urandom % 4) != 0), 16'($urandom), 1'(($urandom % 3) == 0));
    for (int i = 0; i < 150; i++)
      cycle(1'(($urandom % 3) == 0), 16'($urandom), 1'(($urandom % 4) != 0));

    // Full FIFO with simultaneous read and write.
    for (int i = 0; i < 20; i++) if (q.size() < 16) cycle(1'b1, 16'($urandom), 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b1);
    chk("full_rw_level15", 32'(lvl0), 32'd15);

    // Reset with level 9, then confirm no stale data and immediate first write.
    for (int i = 0; i < 20; i++) if (q.size() > 9) cycle(1'b0, 16'h0000, 1'b1);
    chk("pre_reset_level9", 32'(lvl0), 32'd9);
    rst_n = 1'b0;
    cycle(1'b1, 16'($urandom), 1'b1);
    chk("reset_rdata1_mid", 32'(rdata1), 32'h0);
    rst_n = 1'b1;
    cycle(1'b1, 16'h1234, 1'b0);
    chk("fwft_empty_low", 32'(empty1), 32'h0);
    chk("fwft_data", 32'(rdata1), 32'h1234);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("fwft_empty_after_pop", 32'(empty1), 32'h1);
    chk("std_read_after_reset", 32'(rdata0), 32'h1234);

    // FWFT back-to-back reads without bubbles.
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 16'h0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scale_sync_fifo.md
SCALE_SYNC_FIFO -- requirements
Module: scale_sync_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 16: data width, legal 1..1152.
REQ-002 SHALL provide parameter DEPTH_WIDTH, default 11: depth is 2^DEPTH_WIDTH words, legal 4..16.
REQ-003 SHALL provide parameter ALMOST_FULL_NUM, default 1020: almost_full threshold, legal 1..2^DEPTH_WIDTH.
REQ-004 SHALL provide parameter ALMOST_EMPTY_NUM, default 4: almost_empty threshold, legal 0..2^DEPTH_WIDTH-1.
REQ-005 SHALL provide parameter FWFT, default 0: 0 = standard read, 1 = first-word-fall-through.
REQ-006 SHALL have one clock and a synchronous, active-low reset; port order follows.
REQ-007 clk  input  1  clock; all logic on its rising edge.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 wr_en  input  1  write request.
REQ-010 wr_data  input  DATA_WIDTH  write data.
REQ-011 wr_full  output  1  FIFO full.
REQ-012 almost_full  output  1  level >= ALMOST_FULL_NUM.
REQ-013 rd_en  input  1  read request (FWFT=1: pop of the presented word).
REQ-014 rd_data  output  DATA_WIDTH  read data.
REQ-015 rd_empty  output  1  no readable word.
REQ-016 almost_empty  output  1  level <= ALMOST_EMPTY_NUM.
REQ-017 water_level  output  DEPTH_WIDTH+1  stored word count.

Function
REQ-018 Write accepted iff wr_en=1 and wr_full=0; a write while full is dropped, contents unchanged.
REQ-019 Read accepted iff rd_en=1 and rd_empty=0; a read while empty is ignored, pointers unchanged.
REQ-020 Simultaneous read+write: when full, only the read is accepted; when empty, only the write is accepted; otherwise both accepted and water_level unchanged.
REQ-021 Pointers DEPTH_WIDTH bits, wrap from 2^DEPTH_WIDTH-1 to 0.
REQ-022 water_level, wr_full, almost_full, almost_empty all registered; they reflect accepted operations on the clock edge after acceptance, mutually coherent every cycle.
REQ-023 wr_full = (water_level == 2^DEPTH_WIDTH); water_level never exceeds 2^DEPTH_WIDTH.
REQ-024 FWFT=0: rd_empty = (water_level == 0); rd_data updates on the edge following an accepted read with the popped word, else holds.
REQ-025 FWFT=1: rd_empty deasserts exactly one cycle after the first write into an empty FIFO; while rd_empty=0, rd_data shows the oldest word; an accepted read presents the next word on the following edge, or asserts rd_empty if none remain.
REQ-026 FWFT=1: water_level includes the presented word; back-to-back reads at one word per cycle SHALL sustain without bubbles while words remain.
REQ-027 Storage SHALL be a simple dual-port array inferable as block RAM.

Reset
REQ-028 On rst_n=0 at a clock edge: pointers 0, water_level 0, rd_empty 1, almost_empty 1, wr_full 0, almost_full 0, rd_data 0.
REQ-029 Reset mid-operation discards all contents; wr_en/rd_en ignored during reset; first write accepted in the first cycle after rst_n returns high.

Configuration
REQ-030 Macro SCALE_SYNC_FIFO_ERR_FLAG_EN defined: add outputs overflow and underflow (1 bit each, reset 0), sticky-set on a dropped write (REQ-018) / ignored read (REQ-019) respectively, cleared only by reset.
REQ-031 Macro undefined: the overflow/underflow ports and logic SHALL not exist; all other behaviour identical.

Verification (DATA_WIDTH=16, DEPTH_WIDTH=4, ALMOST_FULL_NUM=14, ALMOST_EMPTY_NUM=2)
REQ-032 Write 16 words 0x0000..0x000F, no reads -> almost_full 1 after 14th write, wr_full 1 after 16th, water_level 16; 17th write 0xDEAD dropped, overflow 1 if macro set.
REQ-033 FWFT=0, then read 16 times -> rd_data 0x0000..0x000F each one cycle after rd_en; almost_empty 1 at level 2, rd_empty 1 at level 0; extra read -> rd_data holds 0x000F, underflow 1 if macro set.
REQ-034 Simultaneous wr_en/rd_en every cycle for 40 cycles at level 8 -> water_level stays 8, data order preserved across pointer wrap.
REQ-035 FWFT=1, write 0x1234 into empty -> rd_empty 0 and rd_data 0x1234 next cycle; rd_en pulse -> rd_empty 1 following cycle.
REQ-036 Full FIFO, wr_en+rd_en same cycle -> read accepted, write dropped, water_level 15.
REQ-037 rst_n low one cycle with level 9 -> all outputs per REQ-028 next edge; stale data never returned.
